cdb_writeback_arbiter: RTL and testbench
========================================

// Module: cdb_writeback_arbiter
// PURPOSE
//  Receiving end of the FU result interfaces (alu_data / mem_data / b_data structs). Buffers each FU's
//  completed result and serialises them onto a single registered common data bus (CDB).
//  The CDB feeds PRF write, RS wakeup and ROB completion. Drops wrong-path results on branch flush.
// PARAMETERS
//  FIFO_DEPTH   2   entries per FU source queue (power of two, >=2)
//  ROB_IDX_W    5   ROB index width (matches rob_index fields)
//  PREG_W       7   physical register tag width
// PORTS
//  clk            in   1       rising-edge clock
//  reset_n        in   1       asynchronous, active-low reset
//  alu_in         in   alu_data  result valid when alu_in.fu_alu_done
//  mem_in         in   mem_data  result valid when mem_in.fu_mem_done
//  br_in          in   b_data    result valid when br_in.fu_b_done
//  alu_stall      out  1       source queue full; ALU must hold result
//  mem_stall      out  1       source queue full; MEM must hold result
//  br_stall       out  1       source queue full; BR must hold result
//  flush          in   1       branch mispredict recovery this cycle
//  flush_tag      in   5       ROB index of the mispredicted branch
//  rob_head       in   5       ROB index of the oldest in-flight instruction
//  cdb_valid      out  1       broadcast valid
//  cdb_ptag       out  7       destination physical reg
//  cdb_rob_idx    out  5       ROB entry to mark complete
//  cdb_data       out  32      result value
//  cdb_src        out  2       0=ALU 1=MEM 2=BR
//  prf_we         out  1       cdb_valid && cdb_ptag!=0
// BEHAVIOUR
//  Reset: all queues empty; cdb_valid, prf_we, *_stall = 0; cdb_ptag/rob_idx/data/src = 0; rr ptr = ALU.
//  Enqueue: at posedge, if *_done && !*_stall && !(flush && younger(entry)), push {ptag, rob, data}.
//  *_stall = queue count == FIFO_DEPTH (registered-count based; no same-cycle pop credit).
//  Arbitration (comb.): among non-empty queue heads, round-robin starting at rr ptr (ALU->MEM->BR->ALU).
//  Winner is popped and registered onto the CDB at the same edge. rr ptr advances to winner+1.
//  Latency: result presented in cycle N appears on CDB in cycle N+1 at the earliest; no bypass path.
//  At most one broadcast per cycle. cdb_valid deasserts the cycle after no winner exists.
//  Age: dist(x) = (x - rob_head) mod 2^ROB_IDX_W. younger(x) = dist(x) > dist(flush_tag).
//  Flush: in the same cycle, invalidate every queued entry with younger(rob) and suppress any
//    incoming younger enqueue. The branch itself and older entries survive; compact/skip invalid slots
//    so order within a queue is preserved. If the registered CDB slot would load a younger entry, load
//    nothing (cdb_valid=0). A broadcast already on the CDB this cycle is not retracted.
//  Simultaneous push+pop on a full queue: push is still refused (stall was asserted).
//  ptag==0 (x0 dest): still broadcast for ROB completion; prf_we=0.
//  The BR result data field (link value) is broadcast like ALU. mispredict/pc are not consumed here.
//  Wrap-around: queue pointers wrap mod FIFO_DEPTH; ROB distance arithmetic is unsigned modulo.
//  Reset asserted mid-operation: all queued and in-flight results are discarded immediately (async).
// STRUCTURE
//  types_pkg: alu_data/mem_data/b_data (existing); add cdb_data struct {valid, ptag, rob_idx, data,
//    src} and localparams CDB_SRC_ALU/MEM/BR.
//  One sub-module: wb_src_fifo (parameterised per-source queue with flush-by-age invalidate + count);
//    three instances; arbiter, rr pointer and CDB register live in the top.
// TESTING
//  1) Single ALU push ptag=12 rob=3 data=0xDEAD -> next cycle cdb_valid=1, ptag=12, rob=3, prf_we=1.
//  2) ALU, MEM and BR all push in the same cycle, rr=ALU -> CDB order ALU, MEM, BR on 3 consecutive cycles.
//  3) Hold alu done for 4 cycles with MEM/BR busy -> alu_stall rises once count=2; no result lost/duplicated.
//  4) rob_head=30, queued rob 31,1,2, flush_tag=31 -> 1 and 2 dropped; 31 broadcast; wrap is handled.
//  5) Push ptag=0 rob=7 -> cdb_valid=1, rob_idx=7, prf_we=0.
//  6) Assert reset_n=0 with full queues mid-burst -> cdb_valid=0 and stalls=0 immediately; no broadcast after release.

Source files
------------

// File: rtl/cdb_writeback_arbiter_pkg.sv
// Shared types for the FU result interfaces and the common data bus.
// Also holds the ROB age helper used by both the queues and the arbiter.
package cdb_writeback_arbiter_pkg;

  localparam int unsigned ROB_IDX_W = 5;
  localparam int unsigned PREG_W    = 7;
  localparam int unsigned XLEN      = 32;

  localparam logic [1:0] CDB_SRC_ALU = 2'd0;
  localparam logic [1:0] CDB_SRC_MEM = 2'd1;
  localparam logic [1:0] CDB_SRC_BR  = 2'd2;

  typedef struct packed {
    logic                 fu_alu_done;
    logic [PREG_W-1:0]    ptag;
    logic [ROB_IDX_W-1:0] rob_idx;
    logic [XLEN-1:0]      data;
  } alu_data;

  typedef struct packed {
    logic                 fu_mem_done;
    logic [PREG_W-1:0]    ptag;
    logic [ROB_IDX_W-1:0] rob_idx;
    logic [XLEN-1:0]      data;
  } mem_data;

  typedef struct packed {
    logic                 fu_b_done;
    logic                 mispredict;
    logic [XLEN-1:0]      pc;
    logic [PREG_W-1:0]    ptag;
    logic [ROB_IDX_W-1:0] rob_idx;
    logic [XLEN-1:0]      data;
  } b_data;

  typedef struct packed {
    logic [PREG_W-1:0]    ptag;
    logic [ROB_IDX_W-1:0] rob_idx;
    logic [XLEN-1:0]      data;
  } wb_entry_t;

  typedef struct packed {
    logic                 valid;
    logic [PREG_W-1:0]    ptag;
    logic [ROB_IDX_W-1:0] rob_idx;
    logic [XLEN-1:0]      data;
    logic [1:0]           src;
  } cdb_data_t;

  // Distances from the ROB head wrap modulo 2^ROB_IDX_W, so plain 5-bit subtraction is exact.
  function automatic logic is_younger(input logic [ROB_IDX_W-1:0] x,
                                      input logic [ROB_IDX_W-1:0] head,
                                      input logic [ROB_IDX_W-1:0] tag);
    logic [ROB_IDX_W-1:0] dist_x;
    logic [ROB_IDX_W-1:0] dist_tag;
    dist_x   = x - head;
    dist_tag = tag - head;
    return dist_x > dist_tag;
  endfunction

  function automatic logic [1:0] next_src(input logic [1:0] s);
    return (s == CDB_SRC_BR) ? CDB_SRC_ALU : s + 2'd1;
  endfunction

endpackage

// File: rtl/cdb_writeback_arbiter_wb_src_fifo.sv
// Per-FU result queue. Head lives in slot 0; pop, flush-by-age and push are
// resolved together each cycle by compacting survivors toward the head.
module wb_src_fifo
  import cdb_writeback_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 push,
  input  wb_entry_t            push_entry,
  input  logic                 pop,
  input  logic                 flush,
  input  logic [ROB_IDX_W-1:0] flush_tag,
  input  logic [ROB_IDX_W-1:0] rob_head,
  output wb_entry_t            head,
  output logic                 not_empty,
  output logic                 full
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  wb_entry_t        entries_q [DEPTH];
  wb_entry_t        entries_d [DEPTH];
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             push_ok;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign not_empty = (count_q != '0);
  assign head      = entries_q[0];

  // Full is judged on the registered count: a same-cycle pop does not make room.
  assign push_ok = push && !full && !(flush && is_younger(push_entry.rob_idx, rob_head, flush_tag));

  always_comb begin
    int n;
    n         = 0;
    entries_d = entries_q;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (i < int'(count_q) && !(pop && i == 0) &&
          !(flush && is_younger(entries_q[i].rob_idx, rob_head, flush_tag))) begin
        entries_d[IDX_W'(n)] = entries_q[i];
        n = n + 1;
      end
    end
    if (push_ok) begin
      entries_d[IDX_W'(n)] = push_entry;
      n = n + 1;
    end
    count_d = CNT_W'(n);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      count_q   <= count_d;
      entries_q <= entries_d;
    end
  end

endmodule

// File: rtl/cdb_writeback_arbiter.sv
// Collects ALU/MEM/BR results into per-source queues and broadcasts one per cycle
// on a registered CDB, round-robin across sources, dropping wrong-path results on flush.
module cdb_writeback_arbiter
  import cdb_writeback_arbiter_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  alu_data              alu_in,
  input  mem_data              mem_in,
  input  b_data                br_in,
  output logic                 alu_stall,
  output logic                 mem_stall,
  output logic                 br_stall,
  input  logic                 flush,
  input  logic [ROB_IDX_W-1:0] flush_tag,
  input  logic [ROB_IDX_W-1:0] rob_head,
  output logic                 cdb_valid,
  output logic [PREG_W-1:0]    cdb_ptag,
  output logic [ROB_IDX_W-1:0] cdb_rob_idx,
  output logic [XLEN-1:0]      cdb_data,
  output logic [1:0]           cdb_src,
  output logic                 prf_we
);

  wb_entry_t  alu_entry, mem_entry, br_entry;
  wb_entry_t  alu_head, mem_head, br_head;
  wb_entry_t  win_entry;
  logic [2:0] not_empty;
  logic [2:0] pop;
  logic       win_found;
  logic [1:0] win_src;
  logic       load;
  logic [1:0] rr_q;
  cdb_data_t  cdb_q;
  logic       unused_br;

  assign unused_br = ^{br_in.mispredict, br_in.pc};

  assign alu_entry = '{ptag: alu_in.ptag, rob_idx: alu_in.rob_idx, data: alu_in.data};
  assign mem_entry = '{ptag: mem_in.ptag, rob_idx: mem_in.rob_idx, data: mem_in.data};
  assign br_entry  = '{ptag: br_in.ptag, rob_idx: br_in.rob_idx, data: br_in.data};

  wb_src_fifo #(.DEPTH(FIFO_DEPTH)) u_alu_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (alu_in.fu_alu_done),
    .push_entry (alu_entry),
    .pop        (pop[0]),
    .flush      (flush),
    .flush_tag  (flush_tag),
    .rob_head   (rob_head),
    .head       (alu_head),
    .not_empty  (not_empty[0]),
    .full       (alu_stall)
  );

  wb_src_fifo #(.DEPTH(FIFO_DEPTH)) u_mem_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (mem_in.fu_mem_done),
    .push_entry (mem_entry),
    .pop        (pop[1]),
    .flush      (flush),
    .flush_tag  (flush_tag),
    .rob_head   (rob_head),
    .head       (mem_head),
    .not_empty  (not_empty[1]),
    .full       (mem_stall)
  );

  wb_src_fifo #(.DEPTH(FIFO_DEPTH)) u_br_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (br_in.fu_b_done),
    .push_entry (br_entry),
    .pop        (pop[2]),
    .flush      (flush),
    .flush_tag  (flush_tag),
    .rob_head   (rob_head),
    .head       (br_head),
    .not_empty  (not_empty[2]),
    .full       (br_stall)
  );

  always_comb begin
    logic [1:0] cand;
    win_found = 1'b0;
    win_src   = rr_q;
    cand      = rr_q;
    for (int k = 0; k < 3; k++) begin
      if (!win_found && not_empty[cand]) begin
        win_found = 1'b1;
        win_src   = cand;
      end
      cand = next_src(cand);
    end
  end

  always_comb begin
    unique case (win_src)
      CDB_SRC_ALU: win_entry = alu_head;
      CDB_SRC_MEM: win_entry = mem_head;
      default:     win_entry = br_head;
    endcase
  end

  assign pop[0] = win_found && (win_src == CDB_SRC_ALU);
  assign pop[1] = win_found && (win_src == CDB_SRC_MEM);
  assign pop[2] = win_found && (win_src == CDB_SRC_BR);

  // A winner squashed by this cycle's flush is still popped, but never reaches the bus.
  assign load = win_found && !(flush && is_younger(win_entry.rob_idx, rob_head, flush_tag));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cdb_q <= '0;
      rr_q  <= CDB_SRC_ALU;
    end else begin
      cdb_q.valid <= load;
      if (load) begin
        cdb_q.ptag    <= win_entry.ptag;
        cdb_q.rob_idx <= win_entry.rob_idx;
        cdb_q.data    <= win_entry.data;
        cdb_q.src     <= win_src;
      end
      if (win_found) begin
        rr_q <= next_src(win_src);
      end
    end
  end

  assign cdb_valid   = cdb_q.valid;
  assign cdb_ptag    = cdb_q.ptag;
  assign cdb_rob_idx = cdb_q.rob_idx;
  assign cdb_data    = cdb_q.data;
  assign cdb_src     = cdb_q.src;
  assign prf_we      = cdb_q.valid && (cdb_q.ptag != '0);

endmodule

// File: tb/tb_cdb_writeback_arbiter.sv
// Directed scenarios plus randomized traffic for cdb_writeback_arbiter, checked
// against a queue-based model of the writeback rules.
module tb_cdb_writeback_arbiter;
  import cdb_writeback_arbiter_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  alu_data     alu_in;
  mem_data     mem_in;
  b_data       br_in;
  logic        alu_stall, mem_stall, br_stall;
  logic        flush;
  logic [4:0]  flush_tag, rob_head;
  logic        cdb_valid;
  logic [6:0]  cdb_ptag;
  logic [4:0]  cdb_rob_idx;
  logic [31:0] cdb_data;
  logic [1:0]  cdb_src;
  logic        prf_we;

  cdb_writeback_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .alu_in      (alu_in),
    .mem_in      (mem_in),
    .br_in       (br_in),
    .alu_stall   (alu_stall),
    .mem_stall   (mem_stall),
    .br_stall    (br_stall),
    .flush       (flush),
    .flush_tag   (flush_tag),
    .rob_head    (rob_head),
    .cdb_valid   (cdb_valid),
    .cdb_ptag    (cdb_ptag),
    .cdb_rob_idx (cdb_rob_idx),
    .cdb_data    (cdb_data),
    .cdb_src     (cdb_src),
    .prf_we      (prf_we)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          src;
    logic [6:0]  ptag;
    logic [4:0]  rob;
    logic [31:0] data;
  } ment_t;

  ment_t       mq[$];
  int          rr;
  bit          exp_valid;
  ment_t       exp_e;
  bit          done_v [3];
  logic [6:0]  ptag_v [3];
  logic [4:0]  rob_v  [3];
  logic [31:0] data_v [3];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_younger(input int x, input int head, input int tag);
    return ((x - head + 64) % 32) > ((tag - head + 64) % 32);
  endfunction

  task automatic drive();
    alu_in = '{fu_alu_done: done_v[0], ptag: ptag_v[0], rob_idx: rob_v[0], data: data_v[0]};
    mem_in = '{fu_mem_done: done_v[1], ptag: ptag_v[1], rob_idx: rob_v[1], data: data_v[1]};
    br_in  = '{fu_b_done: done_v[2], mispredict: 1'b0, pc: 32'h1000, ptag: ptag_v[2],
               rob_idx: rob_v[2], data: data_v[2]};
  endtask

  // An FU holding a stalled result keeps it; a new result is only offered when idle.
  task automatic offer(input int s, input logic [6:0] p, input logic [4:0] r, input logic [31:0] d);
    if (!done_v[s]) begin
      done_v[s] = 1'b1;
      ptag_v[s] = p;
      rob_v[s]  = r;
      data_v[s] = d;
    end
  endtask

  // Called at a negedge: drives inputs, predicts the next edge, checks after it.
  task automatic cycle();
    int cnt[3];
    int ws;
    int idx;
    bit acc[3];
    bit gone[3];
    drive();
    cnt = '{0, 0, 0};
    foreach (mq[i]) cnt[mq[i].src]++;
    #1;
    check("alu_stall", 32'(alu_stall), 32'(cnt[0] == DEPTH));
    check("mem_stall", 32'(mem_stall), 32'(cnt[1] == DEPTH));
    check("br_stall",  32'(br_stall),  32'(cnt[2] == DEPTH));
    for (int s = 0; s < 3; s++) begin
      bit squash;
      squash  = flush && m_younger(int'(rob_v[s]), int'(rob_head), int'(flush_tag));
      acc[s]  = done_v[s] && cnt[s] < DEPTH && !squash;
      gone[s] = done_v[s] && (acc[s] || squash);
    end
    ws = -1;
    for (int k = 0; k < 3; k++) begin
      int s;
      s = (rr + k) % 3;
      if (ws < 0 && cnt[s] > 0) ws = s;
    end
    exp_valid = 1'b0;
    if (ws >= 0) begin
      idx = -1;
      foreach (mq[i]) if (idx < 0 && mq[i].src == ws) idx = i;
      if (!(flush && m_younger(int'(mq[idx].rob), int'(rob_head), int'(flush_tag)))) begin
        exp_valid = 1'b1;
        exp_e     = mq[idx];
      end
      mq.delete(idx);
      rr = (ws + 1) % 3;
    end
    if (flush) begin
      for (int i = mq.size() - 1; i >= 0; i--) begin
        if (m_younger(int'(mq[i].rob), int'(rob_head), int'(flush_tag))) mq.delete(i);
      end
    end
    for (int s = 0; s < 3; s++) begin
      if (acc[s]) mq.push_back('{src: s, ptag: ptag_v[s], rob: rob_v[s], data: data_v[s]});
    end
    @(posedge clk);
    #1;
    check("cdb_valid", 32'(cdb_valid), 32'(exp_valid));
    check("prf_we", 32'(prf_we), 32'(exp_valid && exp_e.ptag != 7'd0));
    if (exp_valid) begin
      check("cdb_ptag", 32'(cdb_ptag), 32'(exp_e.ptag));
      check("cdb_rob_idx", 32'(cdb_rob_idx), 32'(exp_e.rob));
      check("cdb_data", cdb_data, exp_e.data);
      check("cdb_src", 32'(cdb_src), 32'(exp_e.src));
    end
    for (int s = 0; s < 3; s++) if (gone[s]) done_v[s] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset_n   = 1'b1;
    flush     = 1'b0;
    flush_tag = '0;
    rob_head  = '0;
    rr        = 0;
    for (int s = 0; s < 3; s++) begin
      done_v[s] = 1'b0;
      ptag_v[s] = '0;
      rob_v[s]  = '0;
      data_v[s] = '0;
    end
    drive();
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(cdb_valid), 32'd0);
    check("rst_prf_we", 32'(prf_we), 32'd0);
    check("rst_stalls", 32'({alu_stall, mem_stall, br_stall}), 32'd0);
    check("rst_fields", 32'({cdb_ptag, cdb_rob_idx, cdb_src}), 32'd0);
    check("rst_data", cdb_data, 32'd0);
    reset_n = 1'b1;

    // Single ALU result.
    offer(0, 7'd12, 5'd3, 32'hDEAD);
    cycle();
    cycle();
    check("t1_ptag", 32'(cdb_ptag), 32'd12);
    check("t1_prf_we", 32'(prf_we), 32'd1);

    // x0 destination still completes in the ROB.
    offer(0, 7'd0, 5'd7, 32'h1234);
    cycle();
    cycle();
    check("t5_rob", 32'(cdb_rob_idx), 32'd7);
    check("t5_prf_we", 32'(prf_we), 32'd0);

    // One BR result brings the pointer back to ALU.
    offer(2, 7'd40, 5'd8, 32'h8);
    repeat (3) cycle();

    // All three at once: ALU, MEM, BR in order.
    offer(0, 7'd21, 5'd9, 32'hA1);
    offer(1, 7'd22, 5'd10, 32'hB2);
    offer(2, 7'd23, 5'd11, 32'hC3);
    cycle();
    cycle();
    check("t2_src0", 32'(cdb_src), 32'(CDB_SRC_ALU));
    cycle();
    check("t2_src1", 32'(cdb_src), 32'(CDB_SRC_MEM));
    cycle();
    check("t2_src2", 32'(cdb_src), 32'(CDB_SRC_BR));
    cycle();

    // Sustained pressure from all FUs until queues back up.
    for (int c = 0; c < 4; c++) begin
      offer(0, 7'(50 + c), 5'(12 + c), 32'h3000 + 32'(c));
      offer(1, 7'(60 + c), 5'(16 + c), 32'h4000 + 32'(c));
      offer(2, 7'(70 + c), 5'(20 + c), 32'h5000 + 32'(c));
      cycle();
    end
    repeat (8) cycle();

    // Flush across the ROB wrap point.
    offer(2, 7'd33, 5'd29, 32'h29);
    repeat (3) cycle();
    rob_head = 5'd30;
    offer(0, 7'd31, 5'd31, 32'h31);
    offer(1, 7'd1, 5'd1, 32'h01);
    offer(2, 7'd2, 5'd2, 32'h02);
    cycle();
    flush     = 1'b1;
    flush_tag = 5'd31;
    cycle();
    check("t4_rob31", 32'(cdb_rob_idx), 32'd31);
    flush = 1'b0;
    cycle();
    check("t4_dropped", 32'(cdb_valid), 32'd0);
    rob_head = 5'd0;

    // Randomized traffic with occasional flushes and a moving ROB head.
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 15) == 0) rob_head = 5'($urandom_range(0, 31));
      for (int s = 0; s < 3; s++) begin
        if ($urandom_range(0, 1) == 1) begin
          offer(s, ($urandom_range(0, 7) == 0) ? 7'd0 : 7'($urandom_range(1, 127)),
                5'(int'(rob_head) + int'($urandom_range(0, 15))), $urandom);
        end
      end
      flush     = ($urandom_range(0, 7) == 0);
      flush_tag = 5'(int'(rob_head) + int'($urandom_range(0, 15)));
      cycle();
    end
    flush = 1'b0;
    for (int s = 0; s < 3; s++) done_v[s] = 1'b0;
    repeat (8) cycle();

    // Asynchronous reset in the middle of a burst.
    for (int c = 0; c < 4; c++) begin
      offer(0, 7'(80 + c), 5'(c), 32'h6000 + 32'(c));
      offer(1, 7'(90 + c), 5'(4 + c), 32'h7000 + 32'(c));
      offer(2, 7'(100 + c), 5'(8 + c), 32'h8000 + 32'(c));
      cycle();
    end
    drive();
    #2 reset_n = 1'b0;
    #1;
    check("t6_valid", 32'(cdb_valid), 32'd0);
    check("t6_prf_we", 32'(prf_we), 32'd0);
    check("t6_stalls", 32'({alu_stall, mem_stall, br_stall}), 32'd0);
    mq.delete();
    rr = 0;
    for (int s = 0; s < 3; s++) done_v[s] = 1'b0;
    drive();
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      cycle();
      check("t6_quiet", 32'(cdb_valid), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
